eq_band_mixer: RTL and testbench

- Synthesis end of the equalizer. Takes one sample from each of the 10 filter-bank bands (lowpass, 64-125 ... 8k-16k, highpass), applies a programmable signed gain per band and sums them into one 24-bit audio sample.
- Uses one time-multiplexed multiply-accumulate (MAC) over 10 cycles per sample.
- Output is rounded and saturated.
- Sits directly after fir_all_filters and before the audio output stage.

---
 rtl/eq_band_mixer.sv | 145 ++++++++++++++
 tb/tb_eq_band_mixer.sv | 315 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/eq_band_mixer.sv
// eq_band_mixer: weights the ten filter-bank band samples by programmable
// signed gains and sums them with a single time-multiplexed MAC. The result is
// rounded half-up, saturated to DATA_W bits and presented with a one-cycle
// out_valid pulse.
module eq_band_mixer #(
    parameter int NUM_BANDS = 10,
    parameter int DATA_W    = 24,
    parameter int GAIN_W    = 16,
    parameter int GAIN_FRAC = 14
) (
    input  logic                        clk,
    input  logic                        reset_n,
    input  logic                        enable,
    input  logic                        sample_valid,
    input  logic [NUM_BANDS*DATA_W-1:0] bands_in,
    input  logic                        gain_wr_en,
    input  logic [3:0]                  gain_addr,
    input  logic [GAIN_W-1:0]           gain_data,
    input  logic                        overrun_clr,
    output logic [DATA_W-1:0]           audio_out,
    output logic                        out_valid,
    output logic                        busy,
    output logic                        overrun
);

    localparam int PROD_W = DATA_W + GAIN_W;
    localparam int ACC_W  = PROD_W + 4;
    localparam int QW     = ACC_W - GAIN_FRAC;

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] MAC  = 2'd1;
    localparam logic [1:0] DONE = 2'd2;

    localparam logic [3:0]               LAST_IDX = 4'(NUM_BANDS - 1);
    localparam logic signed [GAIN_W-1:0] UNITY    = GAIN_W'(2 ** GAIN_FRAC);
    localparam logic signed [ACC_W-1:0]  HALF_LSB = ACC_W'(2 ** (GAIN_FRAC - 1));
    localparam logic signed [QW-1:0]     Q_MAX    = {{(QW - DATA_W + 1){1'b0}}, {(DATA_W - 1){1'b1}}};
    localparam logic signed [QW-1:0]     Q_MIN    = {{(QW - DATA_W + 1){1'b1}}, {(DATA_W - 1){1'b0}}};

    logic [1:0]               state;
    logic [3:0]               idx;
    logic signed [ACC_W-1:0]  acc;
    logic signed [DATA_W-1:0] band_r      [NUM_BANDS];
    logic signed [GAIN_W-1:0] gain_shadow [NUM_BANDS];
    logic signed [GAIN_W-1:0] gain_active [NUM_BANDS];
    logic signed [PROD_W-1:0] prod;
    logic signed [ACC_W-1:0]  prod_ext;
    logic                     capture;
    logic                     drop;

    // Round half-up by adding half an LSB before dropping the fraction, then clamp.
    function automatic logic signed [DATA_W-1:0] round_sat(input logic signed [ACC_W-1:0] a);
        logic signed [ACC_W-1:0] r;
        logic signed [QW-1:0]    q;
        r = a + HALF_LSB;
        q = r[ACC_W-1:GAIN_FRAC];
        if (q > Q_MAX)
            return Q_MAX[DATA_W-1:0];
        else if (q < Q_MIN)
            return Q_MIN[DATA_W-1:0];
        else
            return q[DATA_W-1:0];
    endfunction

    assign capture  = enable && (state == IDLE) && sample_valid;
    assign drop     = enable && (state != IDLE) && sample_valid;
    assign busy     = (state != IDLE);
    assign prod     = PROD_W'(band_r[idx]) * PROD_W'(gain_active[idx]);
    assign prod_ext = {{(ACC_W - PROD_W){prod[PROD_W-1]}}, prod};

    // Shadow gain bank: host writes land here at any time; out-of-range indices are ignored.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < NUM_BANDS; i++) gain_shadow[i] <= UNITY;
        end else if (gain_wr_en && (int'(gain_addr) < NUM_BANDS)) begin
            gain_shadow[gain_addr] <= gain_data;
        end
    end

    // Active gains are snapshotted at capture so a sample never sees a mid-sum gain change.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < NUM_BANDS; i++) gain_active[i] <= UNITY;
        end else if (capture) begin
            gain_active <= gain_shadow;
        end
    end

    // Band samples are latched at capture and stay stable for the whole MAC sweep.
    always_ff @(posedge clk) begin
        if (capture) begin
            for (int i = 0; i < NUM_BANDS; i++) band_r[i] <= bands_in[DATA_W*i +: DATA_W];
        end
    end

    // Sequencer: IDLE -> MAC (one band per clock) -> DONE; everything holds while enable is low.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= IDLE;
            idx   <= 4'd0;
            acc   <= '0;
        end else if (enable) begin
            case (state)
                IDLE: begin
                    if (sample_valid) begin
                        state <= MAC;
                        idx   <= 4'd0;
                        acc   <= '0;
                    end
                end
                MAC: begin
                    acc <= acc + prod_ext;
                    idx <= idx + 4'd1;
                    if (idx == LAST_IDX) state <= DONE;
                end
                DONE:    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    // Output register: rounded, saturated sum published with a single-cycle strobe.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            audio_out <= '0;
            out_valid <= 1'b0;
        end else if (enable && (state == DONE)) begin
            audio_out <= round_sat(acc);
            out_valid <= 1'b1;
        end else begin
            out_valid <= 1'b0;
        end
    end

    // Sticky overrun: a new drop on the same edge as a clear keeps the flag set.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)
            overrun <= 1'b0;
        else if (drop)
            overrun <= 1'b1;
        else if (enable && overrun_clr)
            overrun <= 1'b0;
    end

endmodule

// File: tb/tb_eq_band_mixer.sv
// Testbench for eq_band_mixer: randomized band/gain stimulus compared against
// an arithmetic reference of the weighted, rounded and saturated sum.
module tb_eq_band_mixer;

    logic         clk = 1'b0;
    logic         reset_n;
    logic         enable;
    logic         sample_valid;
    logic [239:0] bands_in;
    logic         gain_wr_en;
    logic [3:0]   gain_addr;
    logic [15:0]  gain_data;
    logic         overrun_clr;
    logic [23:0]  audio_out;
    logic         out_valid;
    logic         busy;
    logic         overrun;

    int checks = 0;
    int errors = 0;
    int bm[10];
    int gm_shadow[10];
    int gm_active[10];

    always #5 clk = ~clk;

    eq_band_mixer dut (
        .clk(clk), .reset_n(reset_n), .enable(enable), .sample_valid(sample_valid),
        .bands_in(bands_in), .gain_wr_en(gain_wr_en), .gain_addr(gain_addr),
        .gain_data(gain_data), .overrun_clr(overrun_clr), .audio_out(audio_out),
        .out_valid(out_valid), .busy(busy), .overrun(overrun)
    );

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    function automatic int ref_mix();
        longint s, r, q;
        s = 0;
        for (int i = 0; i < 10; i++) s += longint'(bm[i]) * longint'(gm_active[i]);
        r = s + 8192;
        q = r / 16384;
        if (r < 0 && (r % 16384) != 0) q = q - 1;
        if (q > 8388607) q = 8388607;
        if (q < -8388608) q = -8388608;
        return int'(q);
    endfunction

    function automatic logic [239:0] pack_bands();
        logic [239:0] p;
        for (int i = 0; i < 10; i++) p[24*i +: 24] = 24'(bm[i]);
        return p;
    endfunction

    function automatic int rand_band();
        return int'($urandom_range(0, 16777215)) - 8388608;
    endfunction

    task automatic write_gain(input int addr, input int val);
        gain_wr_en = 1'b1;
        gain_addr  = 4'(addr);
        gain_data  = 16'(val);
        tick;
        gain_wr_en = 1'b0;
        if (addr < 10) gm_shadow[addr] = val;
    endtask

    task automatic model_reset_gains;
        for (int i = 0; i < 10; i++) gm_shadow[i] = 16384;
    endtask

    // Captures bm, optionally holds enable low / injects a dropped sample, and
    // waits (bounded) for out_valid. lat counts clock edges after the capture edge.
    task automatic run_sample(input int hold_at, input int drop_at, input bit clr_at_drop,
                              input bit cap_wr, input int cap_addr, input int cap_val,
                              output int lat, output int busy_cnt, output int val);
        bands_in     = pack_bands();
        sample_valid = 1'b1;
        gm_active    = gm_shadow;
        if (cap_wr) begin
            gain_wr_en = 1'b1;
            gain_addr  = 4'(cap_addr);
            gain_data  = 16'(cap_val);
            if (cap_addr < 10) gm_shadow[cap_addr] = cap_val;
        end
        tick;
        sample_valid = 1'b0;
        gain_wr_en   = 1'b0;
        lat = 0;
        busy_cnt = 0;
        while (out_valid !== 1'b1 && lat < 40) begin
            if (busy === 1'b1) busy_cnt++;
            sample_valid = (drop_at > 0 && lat + 1 == drop_at);
            overrun_clr  = clr_at_drop && (drop_at > 0 && lat + 1 == drop_at);
            if (sample_valid) bands_in = ~bands_in;
            enable = !(hold_at > 0 && lat >= hold_at && lat < hold_at + 3);
            tick;
            lat++;
        end
        sample_valid = 1'b0;
        overrun_clr  = 1'b0;
        enable       = 1'b1;
        val = int'($signed(audio_out));
    endtask

    task automatic test_reset;
        reset_n = 1'b0;
        #3;
        checks++;
        if (audio_out !== 24'd0 || out_valid !== 1'b0 || busy !== 1'b0 || overrun !== 1'b0) begin
            errors++;
            $display("FAIL reset_outputs got audio=%0d ov=%b busy=%b overrun=%b expected 0 0 0 0",
                     audio_out, out_valid, busy, overrun);
        end
        model_reset_gains();
        tick;
        reset_n = 1'b1;
        tick;
    endtask

    task automatic test_default;
        int lat, bc, val, v2;
        for (int i = 0; i < 10; i++) bm[i] = 100000;
        run_sample(0, 0, 0, 0, 0, 0, lat, bc, val);
        checks++;
        if (lat != 11) begin errors++; $display("FAIL default_latency got %0d expected 11", lat); end
        checks++;
        if (bc != 11) begin errors++; $display("FAIL default_busy_cycles got %0d expected 11", bc); end
        checks++;
        if (val != 1000000) begin errors++; $display("FAIL default_value got %0d expected 1000000", val); end
        tick;
        tick;
        v2 = int'($signed(audio_out));
        checks++;
        if (out_valid !== 1'b0 || v2 != 1000000) begin
            errors++;
            $display("FAIL pulse_and_hold got ov=%b audio=%0d expected ov=0 audio=1000000", out_valid, v2);
        end
        for (int k = 0; k < 3; k++) begin
            for (int i = 0; i < 10; i++) bm[i] = rand_band();
            run_sample(0, 0, 0, 0, 0, 0, lat, bc, val);
            checks++;
            if (val != ref_mix()) begin errors++; $display("FAIL unity_random got %0d expected %0d", val, ref_mix()); end
        end
    endtask

    task automatic test_rounding;
        int lat, bc, val;
        int b3[3];
        int ex[3];
        b3 = '{-200000, 3, -3};
        ex = '{-100000, 2, -1};
        for (int i = 0; i < 10; i++) write_gain(i, (i == 3) ? 8192 : 0);
        for (int k = 0; k < 3; k++) begin
            for (int i = 0; i < 10; i++) bm[i] = rand_band();
            bm[3] = b3[k];
            run_sample(0, 0, 0, 0, 0, 0, lat, bc, val);
            checks++;
            if (val != ex[k] || val != ref_mix()) begin
                errors++;
                $display("FAIL rounding_%0d got %0d expected %0d", b3[k], val, ex[k]);
            end
        end
    endtask

    task automatic test_saturation;
        int lat, bc, val;
        for (int i = 0; i < 10; i++) write_gain(i, 32767);
        for (int i = 0; i < 10; i++) bm[i] = 8388607;
        run_sample(0, 0, 0, 0, 0, 0, lat, bc, val);
        checks++;
        if (val != 8388607) begin errors++; $display("FAIL sat_pos got %0d expected 8388607", val); end
        for (int i = 0; i < 10; i++) bm[i] = -8388608;
        run_sample(0, 0, 0, 0, 0, 0, lat, bc, val);
        checks++;
        if (val != -8388608) begin errors++; $display("FAIL sat_neg got %0d expected -8388608", val); end
    endtask

    task automatic test_random_gains;
        int lat, bc, val;
        for (int k = 0; k < 6; k++) begin
            for (int i = 0; i < 10; i++) begin
                write_gain(i, int'($urandom_range(0, 65535)) - 32768);
                bm[i] = (k < 3) ? rand_band() : (rand_band() / 64);
            end
            run_sample(0, 0, 0, 0, 0, 0, lat, bc, val);
            checks++;
            if (val != ref_mix() || lat != 11) begin
                errors++;
                $display("FAIL random_gains_%0d got %0d lat %0d expected %0d lat 11", k, val, lat, ref_mix());
            end
        end
    endtask

    task automatic test_overrun;
        int lat, bc, val, exp_v, extra;
        for (int i = 0; i < 10; i++) bm[i] = rand_band() / 16;
        run_sample(0, 5, 0, 0, 0, 0, lat, bc, val);
        exp_v = ref_mix();
        checks++;
        if (val != exp_v || lat != 11) begin
            errors++;
            $display("FAIL overrun_first_result got %0d lat %0d expected %0d lat 11", val, lat, exp_v);
        end
        checks++;
        if (overrun !== 1'b1) begin errors++; $display("FAIL overrun_set got %b expected 1", overrun); end
        extra = 0;
        for (int c = 0; c < 15; c++) begin
            tick;
            if (out_valid === 1'b1) extra++;
        end
        checks++;
        if (extra != 0) begin errors++; $display("FAIL overrun_extra_pulses got %0d expected 0", extra); end
        overrun_clr = 1'b1;
        tick;
        overrun_clr = 1'b0;
        checks++;
        if (overrun !== 1'b0) begin errors++; $display("FAIL overrun_clear got %b expected 0", overrun); end
        run_sample(0, 3, 1, 0, 0, 0, lat, bc, val);
        checks++;
        if (overrun !== 1'b1) begin errors++; $display("FAIL overrun_set_wins got %b expected 1", overrun); end
        overrun_clr = 1'b1;
        tick;
        overrun_clr = 1'b0;
    endtask

    task automatic test_hold;
        int lat, bc, val, lat_h, val_h;
        for (int i = 0; i < 10; i++) write_gain(i, int'($urandom_range(0, 32767)));
        for (int i = 0; i < 10; i++) bm[i] = rand_band() / 8;
        run_sample(0, 0, 0, 0, 0, 0, lat, bc, val);
        tick;
        run_sample(4, 0, 0, 0, 0, 0, lat_h, bc, val_h);
        checks++;
        if (lat_h != 14) begin errors++; $display("FAIL hold_latency got %0d expected 14", lat_h); end
        checks++;
        if (val_h != val || val_h != ref_mix()) begin
            errors++;
            $display("FAIL hold_value got %0d expected %0d", val_h, ref_mix());
        end
    endtask

    task automatic test_gain_timing;
        int lat, bc, val;
        for (int i = 0; i < 10; i++) write_gain(i, 16384);
        for (int i = 0; i < 10; i++) bm[i] = 100000;
        run_sample(0, 0, 0, 1, 0, 0, lat, bc, val);
        checks++;
        if (val != 1000000) begin errors++; $display("FAIL gain_same_edge got %0d expected 1000000", val); end
        run_sample(0, 0, 0, 0, 0, 0, lat, bc, val);
        checks++;
        if (val != 900000 || val != ref_mix()) begin errors++; $display("FAIL gain_next_sample got %0d expected 900000", val); end
        write_gain(12, 0);
        run_sample(0, 0, 0, 0, 0, 0, lat, bc, val);
        checks++;
        if (val != 900000) begin errors++; $display("FAIL gain_bad_addr got %0d expected 900000", val); end
    endtask

    task automatic test_mid_reset;
        int lat, bc, val, pulses;
        write_gain(5, -20000);
        for (int i = 0; i < 10; i++) bm[i] = rand_band();
        bands_in = pack_bands();
        sample_valid = 1'b1;
        tick;
        sample_valid = 1'b0;
        for (int c = 0; c < 4; c++) tick;
        reset_n = 1'b0;
        #2;
        checks++;
        if (audio_out !== 24'd0 || out_valid !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL mid_reset_outputs got audio=%0d ov=%b busy=%b expected 0 0 0", audio_out, out_valid, busy);
        end
        model_reset_gains();
        tick;
        reset_n = 1'b1;
        pulses = 0;
        for (int c = 0; c < 15; c++) begin
            tick;
            if (out_valid === 1'b1) pulses++;
        end
        checks++;
        if (pulses != 0) begin errors++; $display("FAIL mid_reset_no_output got %0d pulses expected 0", pulses); end
        for (int i = 0; i < 10; i++) bm[i] = rand_band();
        run_sample(0, 0, 0, 0, 0, 0, lat, bc, val);
        checks++;
        if (val != ref_mix()) begin errors++; $display("FAIL mid_reset_unity_gains got %0d expected %0d", val, ref_mix()); end
    endtask

    initial begin
        reset_n      = 1'b0;
        enable       = 1'b1;
        sample_valid = 1'b0;
        bands_in     = '0;
        gain_wr_en   = 1'b0;
        gain_addr    = 4'd0;
        gain_data    = 16'd0;
        overrun_clr  = 1'b0;
        test_reset();
        test_default();
        test_rounding();
        test_saturation();
        test_random_gains();
        test_overrun();
        test_hold();
        test_gain_timing();
        test_mid_reset();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
